// File: rtl/spectrum_led_pkg.sv
// Shared types and color helpers for the spectrum-to-LED mapping stage.
package spectrum_led_pkg;

  // Mapper control states: CLEAR sweeps zeros into store and strip, RUN maps samples.
  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  // Logical color in GRB order, one byte per channel.
  typedef struct packed {
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
  } grb_t;

  // Reverse the bit order of a byte (the strip driver shifts LSB first).
  function automatic logic [7:0] bitrev8(input logic [7:0] v);
    logic [7:0] o;
    for (int k = 0; k < 8; k++) begin
      o[k] = v[7-k];
    end
    return o;
  endfunction

  // Map an 8-bit level to a dimmed red/green word in driver wire order.
  // Level 0 is forced to black so unlit bars do not glow green.
  function automatic logic [23:0] level_to_grb(input logic [7:0] level,
                                               input int unsigned bright_shift);
    grb_t c;
    c = '0;
    if (level != 8'd0) begin
      c.r = level >> bright_shift;
      c.g = (8'hFF - level) >> bright_shift;
      c.b = 8'd0;
    end
    return {bitrev8(c.b), bitrev8(c.r), bitrev8(c.g)};
  endfunction

endpackage

// File: rtl/spectrum_led_mapper_level_store.sv
// Per-LED peak-hold level memory: combinational read, synchronous write.
// No reset: the clear sweep zeroes every entry before it is ever read.
module led_level_store
  import spectrum_led_pkg::*;
#(
  parameter  int STRIP_LEN  = 120,
  parameter  int LEVEL_BITS = 8,
  localparam int ADDR_BITS  = $clog2(STRIP_LEN)
) (
  input  logic                  clk,
  input  logic [ADDR_BITS-1:0]  rd_addr_i,
  output logic [LEVEL_BITS-1:0] rd_data_o,
  input  logic                  we_i,
  input  logic [ADDR_BITS-1:0]  wr_addr_i,
  input  logic [LEVEL_BITS-1:0] wr_data_i
);

  logic [LEVEL_BITS-1:0] mem_q [STRIP_LEN];

  // Write port: one level update per cycle from either the sweep or the pipeline.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/spectrum_led_mapper.sv
// Spectrum frame to WS2812B frame-buffer mapper with per-LED peak-hold decay,
// frame-length checking and a clear sweep of both level store and strip.
module spectrum_led_mapper
  import spectrum_led_pkg::*;
#(
  parameter  int STRIP_LEN     = 120,
  parameter  int MAG_BITS      = 16,
  parameter  int LEVEL_BITS    = 8,
  parameter  int DECAY         = 4,
  parameter  int BRIGHT_SHIFT  = 2,
  parameter  int COLOR_BITS    = 24,
  localparam int LED_ADDR_BITS = $clog2(STRIP_LEN)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clear,
  input  logic [MAG_BITS-1:0]      s_tdata,
  input  logic                     s_tvalid,
  input  logic                     s_tlast,
  output logic                     s_tready,
  output logic                     write_en,
  output logic [LED_ADDR_BITS-1:0] write_addr,
  output logic [COLOR_BITS-1:0]    write_data,
  output logic                     frame_done,
  output logic                     frame_err
);

  localparam logic [LED_ADDR_BITS-1:0] LAST_IDX = LED_ADDR_BITS'(STRIP_LEN - 1);
  localparam logic [LEVEL_BITS-1:0]    DECAY_L  = LEVEL_BITS'(DECAY);

  state_e                   state_q, state_d;
  logic [LED_ADDR_BITS-1:0] sweep_q, sweep_d;
  logic [LED_ADDR_BITS-1:0] idx_q, idx_d;
  logic                     s1_valid_q, s1_valid_d;
  logic [LED_ADDR_BITS-1:0] s1_idx_q, s1_idx_d;
  logic [LEVEL_BITS-1:0]    s1_mag_q, s1_mag_d;
  logic [LEVEL_BITS-1:0]    level_q, level_d;
  logic                     write_en_q, write_en_d;
  logic [LED_ADDR_BITS-1:0] write_addr_q, write_addr_d;
  logic                     frame_done_q, frame_done_d;
  logic                     frame_err_q, frame_err_d;

  logic                     handshake;
  logic [LEVEL_BITS-1:0]    mag_l;
  logic [LEVEL_BITS-1:0]    level_rd;
  logic [LEVEL_BITS-1:0]    level_dec;
  logic [LEVEL_BITS-1:0]    new_level;
  logic [7:0]               level8;
  logic                     store_we;
  logic [LED_ADDR_BITS-1:0] store_waddr;
  logic [LEVEL_BITS-1:0]    store_wdata;

  assign s_tready  = (state_q == RUN) && !clear;
  assign handshake = s_tvalid && s_tready;
  assign mag_l     = s_tdata[MAG_BITS-1 -: LEVEL_BITS];

  // Only the top LEVEL_BITS of each magnitude drive the bar height.
  generate
    if (MAG_BITS > LEVEL_BITS) begin : g_low_bits
      logic unused_low_mag;
      assign unused_low_mag = ^s_tdata[MAG_BITS-LEVEL_BITS-1:0];
    end
  endgenerate

  led_level_store #(
    .STRIP_LEN  (STRIP_LEN),
    .LEVEL_BITS (LEVEL_BITS)
  ) u_store (
    .clk       (clk),
    .rd_addr_i (s1_idx_q),
    .rd_data_o (level_rd),
    .we_i      (store_we),
    .wr_addr_i (store_waddr),
    .wr_data_i (store_wdata)
  );

  // Peak hold: the stored level decays linearly but never below the new sample.
  always_comb begin
    level_dec = (level_rd > DECAY_L) ? (level_rd - DECAY_L) : '0;
    new_level = (s1_mag_q > level_dec) ? s1_mag_q : level_dec;
  end

  // Bring the registered level to 8 bits for the color mapping.
  generate
    if (LEVEL_BITS == 8) begin : g_lvl_eq
      assign level8 = level_q;
    end else if (LEVEL_BITS < 8) begin : g_lvl_narrow
      assign level8 = {level_q, {(8-LEVEL_BITS){1'b0}}};
    end else begin : g_lvl_wide
      assign level8 = level_q[LEVEL_BITS-1 -: 8];
    end
  endgenerate

  // level_q is held at zero during sweeps, so the sweep writes black.
  assign write_data = level_to_grb(level8, BRIGHT_SHIFT);
  assign write_en   = write_en_q;
  assign write_addr = write_addr_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;

  // Next-state logic: sweep sequencing, sample pipeline and frame-boundary checks.
  always_comb begin
    state_d      = state_q;
    sweep_d      = sweep_q;
    idx_d        = idx_q;
    s1_valid_d   = 1'b0;
    s1_idx_d     = s1_idx_q;
    s1_mag_d     = s1_mag_q;
    level_d      = level_q;
    write_en_d   = 1'b0;
    write_addr_d = write_addr_q;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    store_we     = 1'b0;
    store_waddr  = s1_idx_q;
    store_wdata  = new_level;

    case (state_q)
      CLEAR: begin
        if (clear) begin
          // Restart the sweep from the first LED.
          sweep_d = '0;
          level_d = '0;
        end else begin
          write_en_d   = 1'b1;
          write_addr_d = sweep_q;
          level_d      = '0;
          store_we     = 1'b1;
          store_waddr  = sweep_q;
          store_wdata  = '0;
          if (sweep_q == LAST_IDX) begin
            state_d = RUN;
            sweep_d = '0;
            idx_d   = '0;
          end else begin
            sweep_d = sweep_q + 1'b1;
          end
        end
      end

      RUN: begin
        if (clear) begin
          // Abort: the in-flight sample is dropped (s1_valid_d stays 0).
          state_d = CLEAR;
          sweep_d = '0;
          idx_d   = '0;
          level_d = '0;
        end else begin
          if (s1_valid_q) begin
            level_d      = new_level;
            write_en_d   = 1'b1;
            write_addr_d = s1_idx_q;
            store_we     = 1'b1;
          end
          if (handshake) begin
            s1_valid_d = 1'b1;
            s1_idx_d   = idx_q;
            s1_mag_d   = mag_l;
            if (idx_q == LAST_IDX) begin
              idx_d = '0;
              if (s_tlast) begin
                frame_done_d = 1'b1;
              end else begin
                frame_err_d = 1'b1;
              end
            end else if (s_tlast) begin
              idx_d       = '0;
              frame_err_d = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
      end

      default: begin
        state_d = CLEAR;
        sweep_d = '0;
      end
    endcase
  end

  // State and pipeline registers; reset lands in CLEAR so a sweep follows release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= CLEAR;
      sweep_q      <= '0;
      idx_q        <= '0;
      s1_valid_q   <= 1'b0;
      s1_idx_q     <= '0;
      s1_mag_q     <= '0;
      level_q      <= '0;
      write_en_q   <= 1'b0;
      write_addr_q <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sweep_q      <= sweep_d;
      idx_q        <= idx_d;
      s1_valid_q   <= s1_valid_d;
      s1_idx_q     <= s1_idx_d;
      s1_mag_q     <= s1_mag_d;
      level_q      <= level_d;
      write_en_q   <= write_en_d;
      write_addr_q <= write_addr_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
    end
  end

endmodule

// File: tb/tb_spectrum_led_mapper.sv
// Self-checking bench for spectrum_led_mapper: cycle-indexed scoreboard fed by a
// per-sample reference model, a table of frame vectors, hand-written corner
// sequences and randomized frames.
module tb_spectrum_led_mapper;

  localparam int LEN   = 120;
  localparam int MAGB  = 16;
  localparam int LVB   = 8;
  localparam int DECAY = 4;
  localparam int BS    = 2;
  localparam int AB    = $clog2(LEN);
  localparam int MAXC  = 60000;

  logic          clk;
  logic          reset_n;
  logic          clear;
  logic [MAGB-1:0] s_tdata;
  logic          s_tvalid;
  logic          s_tlast;
  logic          s_tready;
  logic          write_en;
  logic [AB-1:0] write_addr;
  logic [23:0]   write_data;
  logic          frame_done;
  logic          frame_err;

  spectrum_led_mapper #(
    .STRIP_LEN    (LEN),
    .MAG_BITS     (MAGB),
    .LEVEL_BITS   (LVB),
    .DECAY        (DECAY),
    .BRIGHT_SHIFT (BS),
    .COLOR_BITS   (24)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (clear),
    .s_tdata    (s_tdata),
    .s_tvalid   (s_tvalid),
    .s_tlast    (s_tlast),
    .s_tready   (s_tready),
    .write_en   (write_en),
    .write_addr (write_addr),
    .write_data (write_data),
    .frame_done (frame_done),
    .frame_err  (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   cyc;
  bit   chk_en;
  int   n_tests;
  int   n_fail;
  bit   exp_we   [MAXC];
  int   exp_addr [MAXC];
  logic [23:0] exp_data [MAXC];
  bit   exp_done [MAXC];
  bit   exp_err  [MAXC];
  int   run_from;
  int   m_lvl [LEN];
  int   m_idx;
  logic [23:0] obs_data [LEN];
  int   last_addr;
  int   err_seen;
  int   done_seen;

  typedef struct {
    bit          clr;
    logic [15:0] all;
    logic [15:0] b5;
    logic [23:0] exp5;
    int          exp_done;
    int          exp_err;
  } vec_t;
  vec_t vecs [10];

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] o;
    for (int k = 0; k < 8; k++) o[k] = v[7-k];
    return o;
  endfunction

  // Reference color: plain arithmetic on the level, then per-channel reversal.
  function automatic logic [23:0] color(input int lvl);
    int r, g;
    logic [7:0] r8, g8, zero8;
    if (lvl == 0) return 24'h0;
    r = lvl / (1 << BS);
    g = (255 - lvl) / (1 << BS);
    r8 = r[7:0];
    g8 = g[7:0];
    zero8 = 8'h00;
    return {rev8(zero8), rev8(r8), rev8(g8)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  always @(posedge clk) cyc = cyc + 1;

  // Scoreboard: every cycle the outputs must match what the model predicted.
  always @(negedge clk) begin
    if (chk_en && cyc < MAXC) begin
      check("write_en", write_en, exp_we[cyc]);
      if (write_en && exp_we[cyc]) begin
        check("write_addr", write_addr, exp_addr[cyc]);
        check("write_data", write_data, exp_data[cyc]);
      end
      if (write_en && int'(write_addr) < LEN) begin
        obs_data[write_addr] = write_data;
        last_addr = int'(write_addr);
      end
      check("frame_done", frame_done, exp_done[cyc]);
      check("frame_err", frame_err, exp_err[cyc]);
      check("s_tready", s_tready, (cyc >= run_from) && !clear);
      if (frame_err) err_seen++;
      if (frame_done) done_seen++;
    end
  end

  task automatic clr_exp(input int from, input int to);
    for (int k = from; k <= to && k < MAXC; k++) begin
      exp_we[k] = 1'b0;
      exp_done[k] = 1'b0;
      exp_err[k] = 1'b0;
    end
  endtask

  // A sweep entered at cycle s writes LED k on cycle s+k+1 and accepts data from s+LEN.
  task automatic model_sweep(input int s);
    for (int k = 0; k < LEN; k++) begin
      exp_we[s+k+1]   = 1'b1;
      exp_addr[s+k+1] = k;
      exp_data[s+k+1] = 24'h0;
      m_lvl[k] = 0;
    end
    run_from = s + LEN;
    m_idx = 0;
  endtask

  task automatic drive_cycle(input bit v, input logic [15:0] d, input bit l, input bit c,
                             output bit hs);
    int n, i, lvl, dec;
    @(posedge clk);
    #1;
    if (cyc >= MAXC - LEN - 10) begin
      $display("FAIL cycle_budget cyc=%0d actual=exhausted required=below %0d", cyc, MAXC);
      $fatal(1, "cycle budget exhausted");
    end
    s_tvalid = v;
    s_tdata  = d;
    s_tlast  = l;
    clear    = c;
    n  = cyc + 1;
    hs = 1'b0;
    if (c) begin
      clr_exp(n, n + LEN + 4);
      model_sweep(n);
    end else if (v && cyc >= run_from) begin
      hs  = 1'b1;
      i   = m_idx;
      dec = (m_lvl[i] > DECAY) ? m_lvl[i] - DECAY : 0;
      lvl = int'(d >> (MAGB - LVB));
      if (dec > lvl) lvl = dec;
      m_lvl[i] = lvl;
      exp_we[n+1]   = 1'b1;
      exp_addr[n+1] = i;
      exp_data[n+1] = color(lvl);
      if (l && i == LEN - 1) exp_done[n] = 1'b1;
      else if (l || i == LEN - 1) exp_err[n] = 1'b1;
      m_idx = (l || i == LEN - 1) ? 0 : i + 1;
    end
  endtask

  task automatic idle(input int k);
    bit hs;
    repeat (k) drive_cycle(1'b0, 16'h0, 1'b0, 1'b0, hs);
  endtask

  task automatic pulse_clear();
    bit hs;
    drive_cycle(1'b0, 16'h0, 1'b0, 1'b1, hs);
  endtask

  task automatic send(input logic [15:0] d, input bit l);
    bit hs;
    int tries;
    hs = 1'b0;
    tries = 0;
    while (!hs && tries < 400) begin
      drive_cycle(1'b1, d, l, 1'b0, hs);
      tries++;
    end
    check("send_accept", hs, 1'b1);
  endtask

  task automatic wait_run();
    while (cyc < run_from) idle(1);
  endtask

  task automatic send_frame(input logic [15:0] all, input logic [15:0] b5);
    for (int i = 0; i < LEN; i++) send((i == 5) ? b5 : all, i == LEN - 1);
  endtask

  task automatic model_reset();
    for (int k = 0; k < MAXC; k++) begin
      exp_we[k] = 1'b0;
      exp_done[k] = 1'b0;
      exp_err[k] = 1'b0;
    end
    model_sweep(0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_write_en"}, write_en, 1'b0);
    check({tag, "_write_addr"}, write_addr, '0);
    check({tag, "_write_data"}, write_data, 24'h0);
    check({tag, "_frame_done"}, frame_done, 1'b0);
    check({tag, "_frame_err"}, frame_err, 1'b0);
    check({tag, "_s_tready"}, s_tready, 1'b0);
  endtask

  initial begin
    #(MAXC * 10);
    $display("FAIL watchdog time=%0t actual=running required=finished", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, e0;
    bit hs;
    n_tests = 0; n_fail = 0; err_seen = 0; done_seen = 0; last_addr = -1;
    reset_n = 1'b0; clear = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0;
    cyc = 0; chk_en = 1'b0; run_from = LEN; m_idx = 0;

    vecs[0] = '{1'b0, 16'hFF00, 16'hFF00, 24'h00FC00, 1, 0};
    vecs[1] = '{1'b1, 16'h0000, 16'hC800, 24'h004CB0, 1, 0};
    vecs[2] = '{1'b0, 16'h0000, 16'h0000, 24'h008C70, 1, 0};
    vecs[3] = '{1'b0, 16'h0000, 16'h0000, 24'h000CF0, 1, 0};
    vecs[4] = '{1'b1, 16'h0000, 16'h0000, 24'h000000, 1, 0};
    vecs[5] = '{1'b0, 16'h0000, 16'h0300, 24'h0000FC, 1, 0};
    vecs[6] = '{1'b0, 16'h0000, 16'h0000, 24'h000000, 1, 0};
    vecs[7] = '{1'b0, 16'h0000, 16'h05FF, 24'h00807C, 1, 0};
    vecs[8] = '{1'b0, 16'h0000, 16'h0000, 24'h0000FC, 1, 0};
    vecs[9] = '{1'b0, 16'h0000, 16'h0000, 24'h000000, 1, 0};

    // Reset state, then release and let the power-up sweep run.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    model_reset();
    reset_n = 1'b1;
    cyc = 0;
    chk_en = 1'b1;
    wait_run();
    idle(2);
    $display("[TB] power-up sweep done at cyc %0d", cyc);

    // Table-driven frames; bin 5 walks through peak-hold and decay boundaries.
    for (int v = 0; v < 10; v++) begin
      if (vecs[v].clr) begin
        pulse_clear();
        wait_run();
      end
      d0 = done_seen; e0 = err_seen;
      send_frame(vecs[v].all, vecs[v].b5);
      idle(4);
      check("tbl_bin5_data", obs_data[5], vecs[v].exp5);
      check("tbl_done_cnt", done_seen - d0, vecs[v].exp_done);
      check("tbl_err_cnt", err_seen - e0, vecs[v].exp_err);
      $display("[TB] vector %0d bin5=%06h", v, obs_data[5]);
    end

    // Short frame: tlast on the 50th sample.
    e0 = err_seen;
    for (int i = 0; i < 50; i++) send(16'h1000, i == 49);
    idle(4);
    check("short_err_cnt", err_seen - e0, 1);
    send(16'h2000, 1'b0);
    idle(4);
    check("short_next_addr", last_addr, 0);
    for (int i = 1; i < LEN; i++) send(16'h2000, i == LEN - 1);
    idle(2);
    $display("[TB] short frame sequence done");

    // Long frame: 120th sample without tlast, index wraps.
    e0 = err_seen;
    for (int i = 0; i < LEN; i++) send(16'h3000, 1'b0);
    send(16'h4000, 1'b0);
    idle(4);
    check("long_err_cnt", err_seen - e0, 1);
    check("long_next_addr", last_addr, 0);
    for (int i = 1; i < LEN; i++) send(16'h4000, i == LEN - 1);
    idle(2);
    $display("[TB] long frame sequence done");

    // Clear while two samples are in flight.
    send(16'h5000, 1'b0);
    send(16'h6000, 1'b0);
    pulse_clear();
    idle(3);
    check("clear_first_sweep_addr", last_addr, 0);
    wait_run();
    idle(2);
    $display("[TB] clear-in-flight sequence done");

    // Clear mid-sweep restarts the sweep.
    pulse_clear();
    idle(40);
    pulse_clear();
    idle(3);
    check("midsweep_restart_addr", last_addr, 0);
    wait_run();
    idle(2);
    $display("[TB] clear mid-sweep sequence done");

    // Asynchronous reset in the middle of a frame.
    for (int i = 0; i < 30; i++) send(16'hA000, 1'b0);
    @(posedge clk);
    #3;
    chk_en = 1'b0;
    reset_n = 1'b0;
    s_tvalid = 1'b0;
    clear = 1'b0;
    #1;
    check_idle_outputs("async_reset");
    @(negedge clk);
    model_reset();
    reset_n = 1'b1;
    cyc = 0;
    chk_en = 1'b1;
    wait_run();
    idle(2);
    send_frame(16'h0000, 16'h8000);
    idle(4);
    check("post_reset_bin5", obs_data[5], 24'h0004F8);
    $display("[TB] async reset sequence done");

    // Randomized frames with gaps, odd lengths and occasional clears.
    for (int f = 0; f < 12; f++) begin
      int flen;
      int kind;
      kind = $urandom_range(0, 3);
      flen = (kind == 0) ? $urandom_range(1, LEN - 1) :
             (kind == 1) ? $urandom_range(LEN + 1, LEN + 6) : LEN;
      for (int i = 0; i < flen; i++) begin
        if ($urandom_range(0, 3) == 0) idle(1);
        if ($urandom_range(0, 299) == 0) begin
          pulse_clear();
          wait_run();
        end
        send(16'($urandom_range(0, 65535)), i == flen - 1);
      end
      $display("[TB] random frame %0d len=%0d", f, flen);
    end
    idle(6);
    drive_cycle(1'b0, 16'h0, 1'b0, 1'b0, hs);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
